// File: rtl/dfi_phy_responder.sv
// PHY-side DFI responder: decodes column commands from a 4-phase DFI bus, queues burst
// addresses, captures write bursts into a banked memory and returns read bursts after a
// fixed latency. Used as the closed-loop memory model behind the controller.
module dfi_phy_responder #(
  parameter int unsigned COL_BITS = 5,
  parameter int unsigned RD_LAT   = 4,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [16:0] dfi_p0_address,
  input  logic [2:0]  dfi_p0_bank,
  input  logic        dfi_p0_cs_n,
  input  logic        dfi_p0_ras_n,
  input  logic        dfi_p0_cas_n,
  input  logic        dfi_p0_we_n,
  input  logic [63:0] dfi_p0_wrdata,
  input  logic        dfi_p0_wrdata_en,
  input  logic [7:0]  dfi_p0_wrdata_mask,
  input  logic        dfi_p0_rddata_en,
  output logic [63:0] dfi_p0_rddata,
  output logic        dfi_p0_rddata_valid,
  input  logic [16:0] dfi_p1_address,
  input  logic [2:0]  dfi_p1_bank,
  input  logic        dfi_p1_cs_n,
  input  logic        dfi_p1_ras_n,
  input  logic        dfi_p1_cas_n,
  input  logic        dfi_p1_we_n,
  input  logic [63:0] dfi_p1_wrdata,
  input  logic        dfi_p1_wrdata_en,
  input  logic [7:0]  dfi_p1_wrdata_mask,
  input  logic        dfi_p1_rddata_en,
  output logic [63:0] dfi_p1_rddata,
  output logic        dfi_p1_rddata_valid,
  input  logic [16:0] dfi_p2_address,
  input  logic [2:0]  dfi_p2_bank,
  input  logic        dfi_p2_cs_n,
  input  logic        dfi_p2_ras_n,
  input  logic        dfi_p2_cas_n,
  input  logic        dfi_p2_we_n,
  input  logic [63:0] dfi_p2_wrdata,
  input  logic        dfi_p2_wrdata_en,
  input  logic [7:0]  dfi_p2_wrdata_mask,
  input  logic        dfi_p2_rddata_en,
  output logic [63:0] dfi_p2_rddata,
  output logic        dfi_p2_rddata_valid,
  input  logic [16:0] dfi_p3_address,
  input  logic [2:0]  dfi_p3_bank,
  input  logic        dfi_p3_cs_n,
  input  logic        dfi_p3_ras_n,
  input  logic        dfi_p3_cas_n,
  input  logic        dfi_p3_we_n,
  input  logic [63:0] dfi_p3_wrdata,
  input  logic        dfi_p3_wrdata_en,
  input  logic [7:0]  dfi_p3_wrdata_mask,
  input  logic        dfi_p3_rddata_en,
  output logic [63:0] dfi_p3_rddata,
  output logic        dfi_p3_rddata_valid,
  output logic        err_wr_underflow,
  output logic        err_rd_underflow,
  output logic        err_q_overflow,
  output logic        err_multi_cas
);

  localparam int unsigned EntW  = COL_BITS + 1;  // {bank, col[COL_BITS-1:2]}
  localparam int unsigned AddrW = COL_BITS + 3;  // {entry, beat}
  localparam int unsigned Words = 2 ** AddrW;
  localparam int unsigned PtrW  = $clog2(QDEPTH);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(QDEPTH);

  // Per-phase views of the bus, index = phase number
  logic [3:0][16:0] address;
  logic [3:0][2:0]  bank;
  logic [3:0]       cs_n, ras_n, cas_n, we_n, wrdata_en, rddata_en;
  logic [3:0][63:0] wrdata;
  logic [3:0][7:0]  wrdata_mask;

  assign address     = {dfi_p3_address, dfi_p2_address, dfi_p1_address, dfi_p0_address};
  assign bank        = {dfi_p3_bank, dfi_p2_bank, dfi_p1_bank, dfi_p0_bank};
  assign cs_n        = {dfi_p3_cs_n, dfi_p2_cs_n, dfi_p1_cs_n, dfi_p0_cs_n};
  assign ras_n       = {dfi_p3_ras_n, dfi_p2_ras_n, dfi_p1_ras_n, dfi_p0_ras_n};
  assign cas_n       = {dfi_p3_cas_n, dfi_p2_cas_n, dfi_p1_cas_n, dfi_p0_cas_n};
  assign we_n        = {dfi_p3_we_n, dfi_p2_we_n, dfi_p1_we_n, dfi_p0_we_n};
  assign wrdata      = {dfi_p3_wrdata, dfi_p2_wrdata, dfi_p1_wrdata, dfi_p0_wrdata};
  assign wrdata_en   = {dfi_p3_wrdata_en, dfi_p2_wrdata_en, dfi_p1_wrdata_en,
                        dfi_p0_wrdata_en};
  assign wrdata_mask = {dfi_p3_wrdata_mask, dfi_p2_wrdata_mask, dfi_p1_wrdata_mask,
                        dfi_p0_wrdata_mask};
  assign rddata_en   = {dfi_p3_rddata_en, dfi_p2_rddata_en, dfi_p1_rddata_en,
                        dfi_p0_rddata_en};

  // Row bits and burst-offset column bits never matter here
  logic unused_addr;
  always_comb begin
    unused_addr = 1'b0;
    for (int p = 0; p < 4; p++) begin
      unused_addr = unused_addr ^ (^address[p][16:COL_BITS]) ^ (^address[p][1:0]);
    end
  end

  logic [63:0]     mem [Words];
  logic [EntW-1:0] wq_mem [QDEPTH];
  logic [EntW-1:0] rq_mem [QDEPTH];
  logic [PtrW-1:0] wq_rd_q, wq_wr_q, rq_rd_q, rq_wr_q;
  logic [PtrW:0]   wq_cnt_q, rq_cnt_q;
  logic [1:0]      wbeat_q, rbeat_q;

  logic [3:0]       pipe_valid_q [RD_LAT];
  logic [3:0][63:0] pipe_data_q  [RD_LAT];

  // Post-slot queue state; slots of this cycle only see entries pushed in earlier cycles
  logic [PtrW-1:0]     w_ptr, r_ptr;
  logic [PtrW:0]       w_cnt, r_cnt;
  logic [1:0]          wbeat_d, rbeat_d;
  logic                w_under, r_under;
  logic [3:0]          mem_we;
  logic [3:0][AddrW-1:0] mem_waddr;
  logic [3:0][63:0]    rd_data_new;

  logic            cas_any, cas_multi, cas_is_wr;
  logic [EntW-1:0] cas_entry;
  logic            w_push, r_push, q_over;

  // Walk write slots in phase order, popping the write queue when a burst completes
  always_comb begin
    w_ptr     = wq_rd_q;
    w_cnt     = wq_cnt_q;
    wbeat_d   = wbeat_q;
    w_under   = 1'b0;
    mem_we    = '0;
    mem_waddr = '0;
    for (int p = 0; p < 4; p++) begin
      if (wrdata_en[p]) begin
        if (w_cnt == '0) begin
          w_under = 1'b1;
        end else begin
          mem_we[p]    = 1'b1;
          mem_waddr[p] = {wq_mem[w_ptr], wbeat_d};
          if (wbeat_d == 2'd3) begin
            w_ptr = w_ptr + PtrOne;
            w_cnt = w_cnt - CntOne;
          end
          wbeat_d = wbeat_d + 2'd1;
        end
      end
    end
  end

  // Walk read slots in phase order; reads see memory as it was at the start of the cycle
  always_comb begin
    r_ptr       = rq_rd_q;
    r_cnt       = rq_cnt_q;
    rbeat_d     = rbeat_q;
    r_under     = 1'b0;
    rd_data_new = '0;
    for (int p = 0; p < 4; p++) begin
      if (rddata_en[p]) begin
        if (r_cnt == '0) begin
          r_under = 1'b1;  // still returns a zero beat so slot count is preserved
        end else begin
          rd_data_new[p] = mem[{rq_mem[r_ptr], rbeat_d}];
          if (rbeat_d == 2'd3) begin
            r_ptr = r_ptr + PtrOne;
            r_cnt = r_cnt - CntOne;
          end
          rbeat_d = rbeat_d + 2'd1;
        end
      end
    end
  end

  // Column command decode: lowest-phase CAS wins; pushes land after this cycle's pops
  always_comb begin
    cas_any   = 1'b0;
    cas_multi = 1'b0;
    cas_is_wr = 1'b0;
    cas_entry = '0;
    for (int p = 0; p < 4; p++) begin
      if (!cs_n[p] && ras_n[p] && !cas_n[p]) begin
        if (cas_any) begin
          cas_multi = 1'b1;
        end else begin
          cas_any   = 1'b1;
          cas_is_wr = !we_n[p];
          cas_entry = {bank[p], address[p][COL_BITS-1:2]};
        end
      end
    end
    w_push = cas_any && cas_is_wr && (w_cnt != CntFull);
    r_push = cas_any && !cas_is_wr && (r_cnt != CntFull);
    q_over = cas_any && (cas_is_wr ? (w_cnt == CntFull) : (r_cnt == CntFull));
  end

  // Control state, sticky errors and the read-return latency pipeline
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wq_rd_q          <= '0;
      wq_wr_q          <= '0;
      wq_cnt_q         <= '0;
      rq_rd_q          <= '0;
      rq_wr_q          <= '0;
      rq_cnt_q         <= '0;
      wbeat_q          <= '0;
      rbeat_q          <= '0;
      err_wr_underflow <= 1'b0;
      err_rd_underflow <= 1'b0;
      err_q_overflow   <= 1'b0;
      err_multi_cas    <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_valid_q[i] <= '0;
        pipe_data_q[i]  <= '0;
      end
    end else begin
      wbeat_q  <= wbeat_d;
      rbeat_q  <= rbeat_d;
      wq_rd_q  <= w_ptr;
      rq_rd_q  <= r_ptr;
      wq_cnt_q <= w_push ? w_cnt + CntOne : w_cnt;
      rq_cnt_q <= r_push ? r_cnt + CntOne : r_cnt;
      if (w_push) wq_wr_q <= wq_wr_q + PtrOne;
      if (r_push) rq_wr_q <= rq_wr_q + PtrOne;
      err_wr_underflow <= err_wr_underflow | w_under;
      err_rd_underflow <= err_rd_underflow | r_under;
      err_q_overflow   <= err_q_overflow | q_over;
      err_multi_cas    <= err_multi_cas | cas_multi;
      pipe_valid_q[0]  <= rddata_en;
      pipe_data_q[0]   <= rd_data_new;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  // Storage without reset: queue entries and byte-masked memory writes
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      if (w_push) wq_mem[wq_wr_q] <= cas_entry;
      if (r_push) rq_mem[rq_wr_q] <= cas_entry;
      for (int p = 0; p < 4; p++) begin
        if (mem_we[p]) begin
          for (int b = 0; b < 8; b++) begin
            if (!wrdata_mask[p][b]) mem[mem_waddr[p]][b*8 +: 8] <= wrdata[p][b*8 +: 8];
          end
        end
      end
    end
  end

  assign dfi_p0_rddata_valid = pipe_valid_q[RD_LAT-1][0];
  assign dfi_p1_rddata_valid = pipe_valid_q[RD_LAT-1][1];
  assign dfi_p2_rddata_valid = pipe_valid_q[RD_LAT-1][2];
  assign dfi_p3_rddata_valid = pipe_valid_q[RD_LAT-1][3];
  assign dfi_p0_rddata       = pipe_data_q[RD_LAT-1][0];
  assign dfi_p1_rddata       = pipe_data_q[RD_LAT-1][1];
  assign dfi_p2_rddata       = pipe_data_q[RD_LAT-1][2];
  assign dfi_p3_rddata       = pipe_data_q[RD_LAT-1][3];

endmodule

// File: tb/tb_dfi_phy_responder.sv
// Bench for dfi_phy_responder: directed scenarios plus random traffic, every cycle compared
// against a burst-level model built on queues and a flat word array.
module tb_dfi_phy_responder;

  localparam int COL_BITS = 5;
  localparam int RD_LAT   = 4;
  localparam int QDEPTH   = 4;
  localparam int Ring     = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0][16:0] addr;
  logic [3:0][2:0]  bank;
  logic [3:0]       cs_n, ras_n, cas_n, we_n, wen, ren;
  logic [3:0][63:0] wd;
  logic [3:0][7:0]  wm;
  logic [3:0][63:0] rdd;
  logic [3:0]       rdv;
  logic             e_wu, e_ru, e_ov, e_mc;

  dfi_phy_responder #(.COL_BITS(COL_BITS), .RD_LAT(RD_LAT), .QDEPTH(QDEPTH)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .dfi_p0_address(addr[0]), .dfi_p0_bank(bank[0]), .dfi_p0_cs_n(cs_n[0]),
    .dfi_p0_ras_n(ras_n[0]), .dfi_p0_cas_n(cas_n[0]), .dfi_p0_we_n(we_n[0]),
    .dfi_p0_wrdata(wd[0]), .dfi_p0_wrdata_en(wen[0]), .dfi_p0_wrdata_mask(wm[0]),
    .dfi_p0_rddata_en(ren[0]), .dfi_p0_rddata(rdd[0]), .dfi_p0_rddata_valid(rdv[0]),
    .dfi_p1_address(addr[1]), .dfi_p1_bank(bank[1]), .dfi_p1_cs_n(cs_n[1]),
    .dfi_p1_ras_n(ras_n[1]), .dfi_p1_cas_n(cas_n[1]), .dfi_p1_we_n(we_n[1]),
    .dfi_p1_wrdata(wd[1]), .dfi_p1_wrdata_en(wen[1]), .dfi_p1_wrdata_mask(wm[1]),
    .dfi_p1_rddata_en(ren[1]), .dfi_p1_rddata(rdd[1]), .dfi_p1_rddata_valid(rdv[1]),
    .dfi_p2_address(addr[2]), .dfi_p2_bank(bank[2]), .dfi_p2_cs_n(cs_n[2]),
    .dfi_p2_ras_n(ras_n[2]), .dfi_p2_cas_n(cas_n[2]), .dfi_p2_we_n(we_n[2]),
    .dfi_p2_wrdata(wd[2]), .dfi_p2_wrdata_en(wen[2]), .dfi_p2_wrdata_mask(wm[2]),
    .dfi_p2_rddata_en(ren[2]), .dfi_p2_rddata(rdd[2]), .dfi_p2_rddata_valid(rdv[2]),
    .dfi_p3_address(addr[3]), .dfi_p3_bank(bank[3]), .dfi_p3_cs_n(cs_n[3]),
    .dfi_p3_ras_n(ras_n[3]), .dfi_p3_cas_n(cas_n[3]), .dfi_p3_we_n(we_n[3]),
    .dfi_p3_wrdata(wd[3]), .dfi_p3_wrdata_en(wen[3]), .dfi_p3_wrdata_mask(wm[3]),
    .dfi_p3_rddata_en(ren[3]), .dfi_p3_rddata(rdd[3]), .dfi_p3_rddata_valid(rdv[3]),
    .err_wr_underflow(e_wu), .err_rd_underflow(e_ru),
    .err_q_overflow(e_ov), .err_multi_cas(e_mc)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: queues hold burst base word indices (bank*32 + aligned column)
  int          wq[$];
  int          rq[$];
  int          wbeat, rbeat;
  logic [63:0] mmem [256];
  bit          m_wu, m_ru, m_ov, m_mc;
  bit          exp_v [Ring][4];
  logic [63:0] exp_d [Ring][4];

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_returns();
    for (int k = 0; k < Ring; k++) begin
      for (int p = 0; p < 4; p++) begin
        exp_v[k][p] = 1'b0;
        exp_d[k][p] = '0;
      end
    end
  endtask

  // Apply this cycle's inputs to the model (reads before writes, pops before pushes)
  task automatic model_step();
    int n_cas, sel, base, slot;
    if (rst) begin
      wq.delete();
      rq.delete();
      wbeat = 0;
      rbeat = 0;
      {m_wu, m_ru, m_ov, m_mc} = '0;
      clear_returns();
      return;
    end
    slot = (cyc + RD_LAT) % Ring;
    for (int p = 0; p < 4; p++) begin
      if (ren[p]) begin
        exp_v[slot][p] = 1'b1;
        if (rq.size() == 0) begin
          m_ru = 1'b1;
          exp_d[slot][p] = '0;
        end else begin
          exp_d[slot][p] = mmem[rq[0] + rbeat];
          rbeat++;
          if (rbeat == 4) begin
            rbeat = 0;
            void'(rq.pop_front());
          end
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (wen[p]) begin
        if (wq.size() == 0) begin
          m_wu = 1'b1;
        end else begin
          for (int b = 0; b < 8; b++) begin
            if (!wm[p][b]) mmem[wq[0] + wbeat][b*8 +: 8] = wd[p][b*8 +: 8];
          end
          wbeat++;
          if (wbeat == 4) begin
            wbeat = 0;
            void'(wq.pop_front());
          end
        end
      end
    end
    n_cas = 0;
    sel = 0;
    for (int p = 3; p >= 0; p--) begin
      if (!cs_n[p] && ras_n[p] && !cas_n[p]) begin
        n_cas++;
        sel = p;
      end
    end
    if (n_cas > 1) m_mc = 1'b1;
    if (n_cas > 0) begin
      base = int'(bank[sel]) * 32 + (int'(addr[sel]) % 32) / 4 * 4;
      if (!we_n[sel]) begin
        if (wq.size() >= QDEPTH) m_ov = 1'b1;
        else wq.push_back(base);
      end else begin
        if (rq.size() >= QDEPTH) m_ov = 1'b1;
        else rq.push_back(base);
      end
    end
  endtask

  // One clock: model, edge, then compare every output away from the edge
  task automatic tick();
    int s;
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    s = cyc % Ring;
    for (int p = 0; p < 4; p++) begin
      check_eq($sformatf("valid_p%0d", p), 64'(rdv[p]), 64'(exp_v[s][p]));
      check_eq($sformatf("rddata_p%0d", p), rdd[p], exp_d[s][p]);
      exp_v[s][p] = 1'b0;
      exp_d[s][p] = '0;
    end
    check_eq("err_wr_underflow", 64'(e_wu), 64'(m_wu));
    check_eq("err_rd_underflow", 64'(e_ru), 64'(m_ru));
    check_eq("err_q_overflow", 64'(e_ov), 64'(m_ov));
    check_eq("err_multi_cas", 64'(e_mc), 64'(m_mc));
  endtask

  task automatic idle();
    for (int p = 0; p < 4; p++) begin
      addr[p]  = '0;
      bank[p]  = '0;
      cs_n[p]  = 1'b1;
      ras_n[p] = 1'b1;
      cas_n[p] = 1'b1;
      we_n[p]  = 1'b1;
      wd[p]    = '0;
      wm[p]    = '0;
      wen[p]   = 1'b0;
      ren[p]   = 1'b0;
    end
  endtask

  task automatic set_cmd(int p, bit wr, int bk, int col);
    cs_n[p]  = 1'b0;
    ras_n[p] = 1'b1;
    cas_n[p] = 1'b0;
    we_n[p]  = !wr;
    bank[p]  = 3'(bk);
    addr[p]  = 17'($urandom);
    addr[p][4:0] = 5'(col);
  endtask

  task automatic read_burst_all();
    idle();
    ren = 4'hF;
    tick();
    idle();
    repeat (RD_LAT - 1) tick();
  endtask

  initial begin
    int p2, b2;
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    clear_returns();
    wbeat = 0;
    rbeat = 0;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_valid", 64'(rdv), 64'd0);
    check_eq("reset_errs", 64'({e_wu, e_ru, e_ov, e_mc}), 64'd0);
    repeat (20) tick();

    // Basic write then read of bank2 col8
    idle(); set_cmd(0, 1'b1, 2, 8); tick();
    idle(); wen = 4'hF;
    for (int p = 0; p < 4; p++) wd[p] = 64'hA0 + 64'(p);
    tick();
    idle(); set_cmd(0, 1'b0, 2, 8); tick();
    read_burst_all();
    for (int p = 0; p < 4; p++) begin
      check_eq($sformatf("basic_valid_p%0d", p), 64'(rdv[p]), 64'd1);
      check_eq($sformatf("basic_data_p%0d", p), rdd[p], 64'hA0 + 64'(p));
    end

    // Write spanning two cycles with a byte mask over all-ones data
    idle(); set_cmd(2, 1'b1, 5, 12); tick();
    idle(); wen = 4'hF; for (int p = 0; p < 4; p++) wd[p] = '1; tick();
    idle(); set_cmd(1, 1'b1, 5, 13); tick();
    idle(); wen = 4'b1100; wd[2] = 64'h1111_2222_3333_4444;
    wd[3] = 64'h5555_6666_7777_8888; wm[3] = 8'h0F; tick();
    idle(); wen = 4'b0011; wd[0] = 64'h9999_AAAA_BBBB_CCCC; wd[1] = 64'h0123_4567_89AB_CDEF;
    tick();
    idle(); set_cmd(0, 1'b0, 5, 12); tick();
    read_burst_all();
    check_eq("span_beat0", rdd[0], 64'h1111_2222_3333_4444);
    check_eq("span_beat1", rdd[1], 64'h5555_6666_FFFF_FFFF);
    check_eq("span_beat3", rdd[3], 64'h0123_4567_89AB_CDEF);

    // Underflows
    idle(); ren[2] = 1'b1; tick();
    check_eq("rd_underflow_flag", 64'(e_ru), 64'd1);
    idle(); repeat (RD_LAT - 1) tick();
    check_eq("rd_underflow_valid", 64'(rdv[2]), 64'd1);
    check_eq("rd_underflow_data", rdd[2], 64'd0);
    idle(); wen[0] = 1'b1; wd[0] = 64'hDEAD; tick();
    check_eq("wr_underflow_flag", 64'(e_wu), 64'd1);
    idle(); set_cmd(3, 1'b0, 2, 8); tick();
    read_burst_all();
    check_eq("wr_underflow_mem_kept", rdd[0], 64'hA0);

    // Queue overflow: five WRITEs, no data
    for (int i = 0; i < 5; i++) begin
      idle(); set_cmd(0, 1'b1, 7, 4 * i); tick();
      if (i == 3) check_eq("no_overflow_at_4", 64'(e_ov), 64'd0);
    end
    check_eq("overflow_at_5", 64'(e_ov), 64'd1);
    for (int i = 0; i < 4; i++) begin
      idle(); wen = 4'hF;
      for (int p = 0; p < 4; p++) wd[p] = {$urandom, $urandom};
      tick();
    end

    // Two READs in one cycle: only the p1 address is taken
    idle(); set_cmd(0, 1'b1, 3, 20); tick();
    idle(); wen = 4'hF; for (int p = 0; p < 4; p++) wd[p] = 64'hB0 + 64'(p); tick();
    idle(); set_cmd(1, 1'b0, 3, 20); set_cmd(3, 1'b0, 4, 0); tick();
    check_eq("multi_cas_flag", 64'(e_mc), 64'd1);
    read_burst_all();
    for (int p = 0; p < 4; p++) check_eq($sformatf("multi_cas_data_p%0d", p), rdd[p],
                                         64'hB0 + 64'(p));

    // Reset two cycles after rddata_en discards the return
    idle(); set_cmd(0, 1'b0, 2, 8); tick();
    idle(); ren = 4'hF; tick();
    idle(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq("post_reset_no_valid", 64'(rdv), 64'd0);
      tick();
    end

    // Fill the whole memory so random reads always have a defined model value
    for (int i = 0; i <= 64; i++) begin
      idle();
      if (i < 64) set_cmd(0, 1'b1, i / 8, (i % 8) * 4);
      if (i > 0) begin
        wen = 4'hF;
        for (int p = 0; p < 4; p++) wd[p] = {$urandom, $urandom};
      end
      tick();
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      idle();
      if ($urandom_range(0, 2) == 0)
        set_cmd($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                $urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) begin
        p2 = $urandom_range(0, 3);
        b2 = $urandom_range(0, 15);
        {cs_n[p2], ras_n[p2], cas_n[p2], we_n[p2]} = 4'(b2);
        bank[p2] = 3'($urandom_range(0, 7));
        addr[p2] = 17'($urandom);
      end
      for (int p = 0; p < 4; p++) begin
        wen[p] = ($urandom_range(0, 5) == 0);
        ren[p] = ($urandom_range(0, 5) == 0);
        wd[p]  = {$urandom, $urandom};
        wm[p]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
      rst = 1'b0;
    end
    idle();
    repeat (RD_LAT + 2) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
